// File: rtl/cla_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cla_arbiter
// Purpose  : Two-requester front end for an external 5-bit adder. It grants
//            one pending request, loads that requester's operands into the
//            adder's operand registers, waits SETTLE_CYC cycles for the adder
//            to settle, captures the result and holds it as a valid/ready
//            response until it is consumed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE_CYC  adder settle wait in cycles (1..7)
// Configuration macro
//   ROUND_ROBIN_EN  defined   : a tie goes to the requester not served last
//                   undefined : a tie always goes to requester 0
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst_n          in   synchronous active-low reset
//   req0/req1      in   operation pending, held high until granted
//   a0/b0, a1/b1   in   5-bit operands of requester 0/1
//   cin0/cin1      in   carry-in of requester 0/1
//   gnt0/gnt1      out  one-cycle accept pulse
//   ld_en          out  load enable for the adder's operand registers
//   op_a/op_b      out  operands driven to the adder
//   cin_out        out  carry-in driven to the adder
//   sum_in/cout_in in   adder result
//   res_en         out  enable for the adder's result register
//   rsp_valid      out  response valid
//   rsp_ready      in   response consumed when high together with rsp_valid
//   rsp_id         out  index of the requester being answered
//   rsp_sum        out  5-bit sum
//   rsp_cout       out  carry-out
// ============================================================================
module cla_arbiter #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [4:0] a0,
  input  logic [4:0] b0,
  input  logic [4:0] a1,
  input  logic [4:0] b1,
  input  logic       cin0,
  input  logic       cin1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ld_en,
  output logic [4:0] op_a,
  output logic [4:0] op_b,
  output logic       cin_out,
  input  logic [4:0] sum_in,
  input  logic       cout_in,
  output logic       res_en,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [4:0] rsp_sum,
  output logic       rsp_cout,
  input  logic       rsp_ready
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CAPT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [2:0] c_SETTLE_INIT = 3'(SETTLE_CYC);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic       r_gnt0, r_gnt1, r_ld_en, r_res_en, r_rsp_valid;
  logic       w_gnt0_nxt, w_gnt1_nxt, w_ld_en_nxt, w_res_en_nxt, w_rsp_valid_nxt;
  logic       w_take;
  logic       w_load_ops;
  logic       w_sel1;

  logic [4:0] r_hold_a, r_hold_b;
  logic       r_hold_cin, r_hold_id;
  logic [4:0] r_op_a, r_op_b;
  logic       r_cin_out;
  logic [4:0] r_rsp_sum;
  logic       r_rsp_cout, r_rsp_id;

  // Arbitration: w_sel1 high means requester 1 wins this cycle.
`ifdef ROUND_ROBIN_EN
  // Last requester served; resets to 1 so requester 0 wins the first tie.
  logic r_last;
  assign w_sel1 = req1 & (~req0 | ~r_last);
`else
  assign w_sel1 = req1 & ~req0;
`endif

  // Next-state and next-output decode. Every output is registered, so each
  // pulse appears the cycle after the state that requests it.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_gnt0_nxt      = 1'b0;
    w_gnt1_nxt      = 1'b0;
    w_ld_en_nxt     = 1'b0;
    w_res_en_nxt    = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_take          = 1'b0;
    w_load_ops      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 | req1) begin
          w_take      = 1'b1;
          w_gnt1_nxt  = w_sel1;
          w_gnt0_nxt  = ~w_sel1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load_ops  = 1'b1;
        w_ld_en_nxt = 1'b1;
        w_cnt_nxt   = c_SETTLE_INIT;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        // <= guards against a zero count ever stalling the FSM.
        if (r_cnt <= 3'd1) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = ST_CAPT;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_CAPT: begin
        w_res_en_nxt = 1'b1;
        w_state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_ld_en     <= 1'b0;
      r_res_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_hold_a    <= 5'd0;
      r_hold_b    <= 5'd0;
      r_hold_cin  <= 1'b0;
      r_hold_id   <= 1'b0;
      r_op_a      <= 5'd0;
      r_op_b      <= 5'd0;
      r_cin_out   <= 1'b0;
      r_rsp_sum   <= 5'd0;
      r_rsp_cout  <= 1'b0;
      r_rsp_id    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_ld_en     <= w_ld_en_nxt;
      r_res_en    <= w_res_en_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_take) begin
        r_hold_a   <= w_sel1 ? a1 : a0;
        r_hold_b   <= w_sel1 ? b1 : b0;
        r_hold_cin <= w_sel1 ? cin1 : cin0;
        r_hold_id  <= w_sel1;
`ifdef ROUND_ROBIN_EN
        r_last     <= w_sel1;
`endif
      end
      // Operands change only here, so they stay put from LOAD through CAPT.
      if (w_load_ops) begin
        r_op_a    <= r_hold_a;
        r_op_b    <= r_hold_b;
        r_cin_out <= r_hold_cin;
      end
      // The adder presents its gated result while res_en is high; sample it
      // on that same cycle so the response is ready when rsp_valid rises.
      if (r_res_en) begin
        r_rsp_sum  <= sum_in;
        r_rsp_cout <= cout_in;
        r_rsp_id   <= r_hold_id;
      end
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign ld_en     = r_ld_en;
  assign res_en    = r_res_en;
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign cin_out   = r_cin_out;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;

endmodule
`default_nettype wire

// File: tb/tb_cla_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_arbiter
// Purpose  : Directed self-checking bench for cla_arbiter. One instance runs
//            with SETTLE_CYC=1, a second with SETTLE_CYC=7. Each instance
//            drives a small adder model: ld_en-gated operand registers, a
//            5-bit adder, result presented only while res_en is high.
// Revision : 1.0 - initial release
// Configuration macro: ROUND_ROBIN_EN selects the expected tie sequence.
// ============================================================================
module tb_cla_arbiter;

  logic clk;
  logic rst_n;
  logic req0, req1, cin0, cin1, rsp_ready;
  logic [4:0] a0, b0, a1, b1;
  logic gnt0, gnt1, ld_en, cin_out, res_en, rsp_valid, rsp_id, rsp_cout, cout_in;
  logic [4:0] op_a, op_b, sum_in, rsp_sum;

  // Second instance (SETTLE_CYC=7), only requester 0 used.
  logic req7, rdy7, cin7i, z1;
  logic [4:0] a7, b7, z5;
  logic g70, g71, ld7, cin7o, res7, v7, id7, cout7r, cout7;
  logic [4:0] op7a, op7b, sum7, sum7r;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_arbiter #(.SETTLE_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .ld_en(ld_en), .op_a(op_a), .op_b(op_b),
    .cin_out(cin_out), .sum_in(sum_in), .cout_in(cout_in), .res_en(res_en),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ready(rsp_ready)
  );

  cla_arbiter #(.SETTLE_CYC(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .req0(req7), .req1(z1),
    .a0(a7), .b0(b7), .a1(z5), .b1(z5), .cin0(cin7i), .cin1(z1),
    .gnt0(g70), .gnt1(g71), .ld_en(ld7), .op_a(op7a), .op_b(op7b),
    .cin_out(cin7o), .sum_in(sum7), .cout_in(cout7), .res_en(res7),
    .rsp_valid(v7), .rsp_id(id7), .rsp_sum(sum7r),
    .rsp_cout(cout7r), .rsp_ready(rdy7)
  );

  // Adder model for each instance.
  logic [4:0] r_ra, r_rb, r_ra7, r_rb7;
  logic       r_rc, r_rc7;
  logic [5:0] w_add, w_add7;
  always @(posedge clk) begin
    if (ld_en) begin r_ra <= op_a; r_rb <= op_b; r_rc <= cin_out; end
    if (ld7) begin r_ra7 <= op7a; r_rb7 <= op7b; r_rc7 <= cin7o; end
  end
  assign w_add   = {1'b0, r_ra} + {1'b0, r_rb} + {5'd0, r_rc};
  assign w_add7  = {1'b0, r_ra7} + {1'b0, r_rb7} + {5'd0, r_rc7};
  assign sum_in  = res_en ? w_add[4:0] : 5'd0;
  assign cout_in = res_en & w_add[5];
  assign sum7    = res7 ? w_add7[4:0] : 5'd0;
  assign cout7   = res7 & w_add7[5];

  logic [22:0] w_outs, w_outs7;
  assign w_outs  = {gnt0, gnt1, ld_en, res_en, rsp_valid, rsp_id, rsp_cout,
                    rsp_sum, op_a, op_b, cin_out};
  assign w_outs7 = {g70, g71, ld7, res7, v7, id7, cout7r, sum7r, op7a, op7b, cin7o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant on the SETTLE_CYC=1 instance and follows the operation
  // through to the handshake (rsp_ready assumed high).
  task automatic serve(input string tag, input int exp_id, input int exp_a,
                       input int exp_b, input int exp_sum, input int exp_cout,
                       input bit drop);
    int n;
    int lat;
    int res_at;
    n = 0;
    while (!(gnt0 || gnt1) && n < 40) begin tick(); n++; end
    check({tag, "_gnt"}, 32'(gnt0 | gnt1), 1);
    check({tag, "_gnt_id"}, 32'(gnt1), exp_id);
    check({tag, "_gnt_excl"}, 32'(gnt0 & gnt1), 0);
    if (drop) begin
      if (gnt1) req1 = 1'b0;
      else      req0 = 1'b0;
    end
    tick();
    check({tag, "_ld_en"}, 32'(ld_en), 1);
    check({tag, "_op_a"}, 32'(op_a), exp_a);
    check({tag, "_op_b"}, 32'(op_b), exp_b);
    lat = 1;
    res_at = -1;
    while (!rsp_valid && lat < 40) begin
      if (res_en) res_at = lat;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_res_en_cyc"}, res_at, 3);
    check({tag, "_op_a_stable"}, 32'(op_a), exp_a);
    check({tag, "_sum"}, 32'(rsp_sum), exp_sum);
    check({tag, "_cout"}, 32'(rsp_cout), exp_cout);
    check({tag, "_id"}, 32'(rsp_id), exp_id);
    tick();
    check({tag, "_valid_drop"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    int ld_at;
    int res_at;
    int tie_ids[4];
    logic seen;

`ifdef ROUND_ROBIN_EN
    tie_ids = '{0, 1, 0, 1};
`else
    tie_ids = '{0, 0, 0, 0};
`endif

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
    a0 = 5'd0; b0 = 5'd0; a1 = 5'd0; b1 = 5'd0; rsp_ready = 1'b1;
    req7 = 1'b0; rdy7 = 1'b1; cin7i = 1'b0; a7 = 5'd13; b7 = 5'd22;
    z1 = 1'b0; z5 = 5'd0;

    // Reset state
    repeat (3) tick();
    check("reset_outs", 32'(w_outs), 0);
    check("reset_outs7", 32'(w_outs7), 0);
    rst_n = 1'b1;
    tick();

    // Single op: 13 + 22 = 35 -> sum 3, carry 1
    a0 = 5'd13; b0 = 5'd22; cin0 = 1'b0; req0 = 1'b1;
    serve("single", 0, 13, 22, 3, 1, 1);

    // Backpressure: 20 + 5 + 1 = 26, req1 pending during RESP
    a0 = 5'd20; b0 = 5'd5; cin0 = 1'b1; req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 40) begin tick(); n++; end
    check("bp_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    a1 = 5'd31; b1 = 5'd0; cin1 = 1'b1; req1 = 1'b1;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("bp_valid_seen", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_sum", 32'(rsp_sum), 26);
      check("bp_hold_cout", 32'(rsp_cout), 0);
      check("bp_no_gnt1", 32'(gnt1), 0);
      tick();
    end
    check("bp_last_valid", 32'(rsp_valid), 1);
    check("bp_id", 32'(rsp_id), 0);
    rsp_ready = 1'b1;
    tick();
    check("bp_after_valid", 32'(rsp_valid), 0);
    check("bp_after_gnt1", 32'(gnt1), 0);
    tick();
    check("bp_gnt1_follow", 32'(gnt1), 1);
    // Boundary: 31 + 0 + 1 = 32 -> sum 0, carry 1
    serve("bnd31", 1, 31, 0, 0, 1, 1);

    // Boundary: 0 + 0 + 0
    a1 = 5'd0; b1 = 5'd0; cin1 = 1'b0; req1 = 1'b1;
    serve("bnd0", 1, 0, 0, 0, 0, 1);

    // Reset during SETTLE aborts the operation
    a0 = 5'd3; b0 = 5'd4; cin0 = 1'b0; req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 40) begin tick(); n++; end
    check("rst_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    tick();
    check("rst_pre_ld_en", 32'(ld_en), 1);
    rst_n = 1'b0;
    tick();
    check("rst_outs", 32'(w_outs), 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | rsp_valid | gnt0 | gnt1;
    end
    check("rst_no_resp", 32'(seen), 0);

    // Tie with both requests held: 1+2=3 for requester 0, 10+5=15 for 1
    a0 = 5'd1; b0 = 5'd2; cin0 = 1'b0;
    a1 = 5'd10; b1 = 5'd5; cin1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve($sformatf("tie%0d", i), tie_ids[i],
            (tie_ids[i] == 1) ? 10 : 1, (tie_ids[i] == 1) ? 5 : 2,
            (tie_ids[i] == 1) ? 15 : 3, 0, 0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Request after reset: 7 + 8 = 15
    a1 = 5'd7; b1 = 5'd8; cin1 = 1'b0; req1 = 1'b1;
    serve("rst_after", 1, 7, 8, 15, 0, 1);

    // SETTLE_CYC=7 instance: 13 + 22 -> sum 3, carry 1
    req7 = 1'b1;
    n = 0;
    while (!g70 && n < 40) begin tick(); n++; end
    check("s7_gnt0", 32'(g70), 1);
    req7 = 1'b0;
    cyc = 0; ld_at = -1; res_at = -1;
    while (!v7 && cyc < 40) begin
      if (ld7) ld_at = cyc;
      if (res7) res_at = cyc;
      tick();
      cyc++;
    end
    check("s7_latency", cyc, 10);
    check("s7_ld_cyc", ld_at, 1);
    check("s7_spacing", res_at - ld_at, 8);
    check("s7_sum", 32'(sum7r), 3);
    check("s7_cout", 32'(cout7r), 1);
    check("s7_id", 32'(id7), 0);
    tick();
    check("s7_valid_drop", 32'(v7), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_arbiter.md
CLA_ARBITER -- requirements
Module: cla_arbiter

Interface
REQ-001 The block SHALL have a parameter SETTLE_CYC, default 1, setting adder settle wait in cycles (legal 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports req0/req1, input, 1 bit each: requester 0/1 operation pending; held high until granted.
REQ-005 The block SHALL have ports a0/b0/a1/b1, input, 5 bits each: requester operands.
REQ-006 The block SHALL have ports cin0/cin1, input, 1 bit each: requester carry-in.
REQ-007 The block SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle accept pulse; operands sampled that cycle.
REQ-008 The block SHALL have port ld_en, output, 1 bit: enable for the adder's 5-bit operand registers.
REQ-009 The block SHALL have ports op_a/op_b, output, 5 bits each, and cin_out, output, 1 bit: operands and carry-in driven to the adder.
REQ-010 The block SHALL have ports sum_in, input, 5 bits, and cout_in, input, 1 bit: adder result.
REQ-011 The block SHALL have port res_en, output, 1 bit: enable for the adder's result register.
REQ-012 The block SHALL have ports rsp_valid, rsp_id (0/1), rsp_cout (1 bit), all outputs, and rsp_sum, output, 5 bits: the response.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: response consumed when high with rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SETTLE, CAPT, RESP; all outputs registered.
REQ-015 In IDLE with any req high, the block SHALL pulse the selected gnt, latch its a/b/cin into hold registers and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-016 In LOAD, ld_en SHALL be 1 for exactly one cycle, with op_a/op_b/cin_out equal to the hold registers; the next state SHALL be SETTLE.
REQ-017 op_a/op_b/cin_out SHALL stay stable from LOAD through CAPT.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles via a 3-bit down-counter, then go to CAPT.
REQ-019 In CAPT, res_en SHALL be 1 for one cycle and sum_in/cout_in SHALL be captured into rsp_sum/rsp_cout; the next state SHALL be RESP.
REQ-020 In RESP, rsp_valid SHALL be 1 and the rsp_* outputs stable until rsp_ready=1; on that handshake the block SHALL go to IDLE next cycle with rsp_valid=0.
REQ-021 Latency: a grant in cycle 0 SHALL give rsp_valid first high in cycle 3+SETTLE_CYC.
REQ-022 Requests while not in IDLE SHALL be ignored (no gnt); at most one gnt SHALL be high per cycle.
REQ-023 rsp_id SHALL equal the index of the granted requester.

Reset
REQ-024 With rst_n=0 at posedge clk, the state SHALL become IDLE, the settle counter 0, and gnt0, gnt1, ld_en, res_en, rsp_valid, rsp_id, rsp_sum, rsp_cout, op_a, op_b and cin_out all 0.
REQ-025 Reset mid-operation SHALL discard the in-flight operation with no response, and the priority pointer SHALL reset so requester 0 wins the next tie.

Configuration
REQ-026 With ROUND_ROBIN_EN defined, a tie SHALL be granted to the requester not served last; the pointer SHALL update on each grant and reset to "last served = 1".
REQ-027 Without ROUND_ROBIN_EN, a tie SHALL always be granted to requester 0 (fixed priority) and no pointer SHALL exist.

Verification
REQ-028 Bench wiring: op_a/op_b/cin_out SHALL pass through ld_en-gated 5-bit registers and a 5-bit adder into sum_in/cout_in, with the result gated by res_en.
REQ-029 Single op, SETTLE_CYC=1: req0, a0=13, b0=22, cin0=0 -> gnt0 in cycle 0; rsp_valid in cycle 4 with rsp_sum=3, rsp_cout=1, rsp_id=0.
REQ-030 Tie: req0 and req1 both held high, rsp_ready=1 -> grants 0,1,0,1 with ROUND_ROBIN_EN; 0,0,0 (req1 starved) without it.
REQ-031 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_sum stable, no gnt to a pending req1; gnt1 follows 1 cycle after the handshake.
REQ-032 Boundary: a1=31, b1=0, cin1=1 -> rsp_sum=0, rsp_cout=1; a1=0, b1=0, cin1=0 -> rsp_sum=0, rsp_cout=0.
REQ-033 Reset: rst_n=0 during SETTLE -> next cycle all outputs 0 and state IDLE; no rsp_valid for the aborted op; a following req1 with a1=7, b1=8 -> rsp_sum=15.
REQ-034 SETTLE_CYC=7: single op -> ld_en to res_en spacing of 8 cycles; rsp_valid in cycle 10.
